// File: rtl/rect_pos_ctl_pkg.sv
// Shared VGA screen/rectangle constants and position-controller state encodings.
package rect_pos_ctl_pkg;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam int RECT_W   = 48;
    localparam int RECT_H   = 64;
    localparam int FLOOR_Y  = SCREEN_H - RECT_H;
    localparam int X_MAX    = SCREEN_W - RECT_W;

    localparam int POS_W = 12;
    localparam int VEL_W = 8;

    typedef enum logic [1:0] {
        ST_FOLLOW = 2'b00,
        ST_FALL   = 2'b01,
        ST_LANDED = 2'b10
    } rect_state_e;

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] v,
        input logic [POS_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rect_pos_ctl_edge_rise.sv
// Single-cycle rising-edge pulse; combinational on the input, registered history.
module edge_rise (
    input  logic pclk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/rect_pos_ctl.sv
// Frame-synchronous rectangle position controller: follow the mouse or fall and land.
module rect_pos_ctl
    import rect_pos_ctl_pkg::*;
#(
    parameter int GRAVITY = 1,
    parameter int VMAX    = 32
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk_in,
    input  logic [POS_W-1:0]  mouse_xpos,
    input  logic [POS_W-1:0]  mouse_ypos,
    input  logic              mouse_left,
    output logic [POS_W-1:0]  xpos,
    output logic [POS_W-1:0]  ypos,
    output logic [1:0]        state_out
);

    localparam logic [POS_W-1:0] X_LIM   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIM   = POS_W'(FLOOR_Y);
    localparam logic [POS_W:0]   FLOOR13 = (POS_W+1)'(FLOOR_Y);
    localparam logic [VEL_W:0]   GRAV_V  = (VEL_W+1)'(GRAVITY);
    localparam logic [VEL_W:0]   VMAX_V  = (VEL_W+1)'(VMAX);

    logic tick;
    logic click;

    edge_rise u_tick (
        .pclk  (pclk),
        .rst   (rst),
        .in    (vblnk_in),
        .pulse (tick)
    );

    edge_rise u_click (
        .pclk  (pclk),
        .rst   (rst),
        .in    (mouse_left),
        .pulse (click)
    );

    rect_state_e      state_q, state_d;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic             click_pend_q, click_pend_d;

    logic             pend;
    logic [VEL_W:0]   vel_sum;
    logic [VEL_W-1:0] vel_n;
    logic [POS_W:0]   y_n;

    always_comb begin
        state_d      = state_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        vel_d        = vel_q;
        click_pend_d = click_pend_q | click;
        pend         = click_pend_q | click;
        vel_sum      = {1'b0, vel_q} + GRAV_V;
        vel_n        = (vel_sum > VMAX_V) ? VMAX_V[VEL_W-1:0]
                                          : vel_sum[VEL_W-1:0];
        y_n          = {1'b0, ypos_q} + (POS_W+1)'(vel_n);

        if (tick) begin
            // Any pending click is used or discarded by this tick.
            click_pend_d = 1'b0;
            unique case (state_q)
                ST_FOLLOW: begin
                    xpos_d = clamp_pos(mouse_xpos, X_LIM);
                    ypos_d = clamp_pos(mouse_ypos, Y_LIM);
                    if (pend) begin
                        vel_d   = '0;
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (y_n >= FLOOR13) begin
                        ypos_d  = Y_LIM;
                        vel_d   = '0;
                        state_d = ST_LANDED;
                    end else begin
                        ypos_d = y_n[POS_W-1:0];
                        vel_d  = vel_n;
                    end
                end
                ST_LANDED: begin
                    if (pend) begin
                        state_d = ST_FOLLOW;
                    end
                end
                default: begin
                    state_d = ST_FOLLOW;
                    vel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= ST_FOLLOW;
            xpos_q       <= '0;
            ypos_q       <= '0;
            vel_q        <= '0;
            click_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            vel_q        <= vel_d;
            click_pend_q <= click_pend_d;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign state_out = state_q;

endmodule
